beam_sweep_scheduler: RTL and testbench
=======================================

// Module: beam_sweep_scheduler
// PURPOSE
// Sequences transmit beamforming: steps a steering angle index across the sweep and fetches sin/sign per angle from the sine LUT.
// Holds sin_theta/sign_bit stable for the transmit beamformer and gates its output with a fixed-length burst per period.
// Marks the listen window for the receive path. Sits between top-level control, the sine LUT and the transmit beamformer.
// PARAMETERS
// PERIOD_DURATION  16777216  cycles from one period_start to the next (one angle per period)
// BURST_DURATION   524288    cycles tx_enable is high per period
// SETTLE_CYCLES    2500      cycles between sin latch and burst (one 40 kHz PWM period)
// NUM_ANGLES       16        number of sweep positions, >=2
// SIN_WIDTH        17        width of sin magnitude
// PORTS
// clk_in          in   1                       system clock
// rst_in          in   1                       asynchronous active-low reset
// enable_in       in   1                       level; run sweep while high
// hold_in         in   1                       level; repeat current angle instead of stepping
// sin_valid_in    in   1                       LUT response strobe for sin_req_out
// sin_in          in   SIN_WIDTH               |sin| from LUT, valid with sin_valid_in
// sign_in         in   1                       sign from LUT, valid with sin_valid_in
// sin_req_out     out  1                       level request to LUT; high only in FETCH
// angle_idx_out   out  $clog2(NUM_ANGLES)      angle being fetched/transmitted
// sin_theta_out   out  SIN_WIDTH               latched sin to beamformer
// sign_bit_out    out  1                       latched sign to beamformer
// tx_enable_out   out  1                       AND-gate for beamformer tx_out; high only in BURST
// period_start_out out 1                       1-cycle pulse, first FETCH cycle of each period
// listen_out      out  1                       high in LISTEN (receive window)
// overrun_out     out  1                       sticky: period ran over PERIOD_DURATION
// busy_out        out  1                       high in any state except IDLE
// BEHAVIOUR
// - Reset (async, rst_in=0): state IDLE; all outputs 0; angle_idx=0, direction=up; period_cnt=0; overrun cleared.
// - States: IDLE, FETCH, SETTLE, BURST, LISTEN. All outputs registered / decoded from the state register.
// - IDLE: enable_in=1 -> FETCH next cycle, period_cnt=0, period_start pulse in that first FETCH cycle.
// - period_cnt: 0 in first FETCH cycle, +1 every cycle, 32 bits, saturates (no wrap).
// - FETCH: sin_req=1. On sin_valid_in, latch sin_in/sign_in -> SETTLE.
//   sin_valid_in outside FETCH is ignored. sin_theta/sign_bit change only on that latch edge.
// - SETTLE: exactly SETTLE_CYCLES cycles (0 = skip), then BURST.
// - BURST: exactly BURST_DURATION cycles with tx_enable=1, then LISTEN.
// - LISTEN: listen=1; exits after the cycle where period_cnt==PERIOD_DURATION-1.
//   If period_cnt already >= PERIOD_DURATION-1 on entry: one LISTEN cycle, set overrun.
// - LISTEN exit: if enable_in=0 -> IDLE (angle state retained; the sweep is not reset).
//   Else advance angle -> FETCH with period_cnt=0 and a period_start pulse.
// - Angle advance (ping-pong, endpoints not repeated):
//   up: idx+1, at N-1 flip to down and step to N-2; down: idx-1, at 0 flip to up and step to 1.
//   hold_in=1 sampled at LISTEN exit -> idx/direction unchanged.
// - enable_in=0 mid-period: current period completes (burst never truncated); checked only at LISTEN exit.
// - Reset mid-burst: tx_enable falls asynchronously with rst_in; no partial state survives.
// - Back-to-back periods: LISTEN exit and FETCH entry are adjacent cycles; no dead cycle.
// TESTING (PERIOD=64, BURST=8, SETTLE=4, NUM_ANGLES=4; LUT answers 2 cycles after sin_req)
// reset then enable=1 -> period_start at cycle 1 (c1), sin latched c3, tx_enable c7..c14, listen c15..c64, next period_start c65
// free-run 8 periods -> angle_idx sequence 0,1,2,3,2,1,0,1; period_start every 64 cycles exactly
// hold_in=1 during period 2 -> angle 1 repeated; sweep resumes 2,3 after release
// LUT delayed 70 cycles -> overrun=1 sticky, one LISTEN cycle, next period starts immediately; tx_enable still 8 cycles
// enable=0 during BURST -> burst completes 8 cycles, listen to period end, then IDLE, busy=0, no sin_req
// rst_in low mid-BURST -> tx_enable, busy, sin_req, listen all 0 asynchronously; restart from angle 0 up

Source files
------------

// File: rtl/beam_sweep_scheduler.sv
// Transmit sweep sequencer: steps the steering angle ping-pong across the sweep, fetches sin/sign
// from the LUT, then runs settle, burst and listen phases on a fixed period.
`timescale 1ns/1ps
module beam_sweep_scheduler #(
  parameter int unsigned PERIOD_DURATION = 16777216,
  parameter int unsigned BURST_DURATION  = 524288,
  parameter int unsigned SETTLE_CYCLES   = 2500,
  parameter int unsigned NUM_ANGLES      = 16,
  parameter int unsigned SIN_WIDTH       = 17
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          hold_in,
  input  logic                          sin_valid_in,
  input  logic [SIN_WIDTH-1:0]          sin_in,
  input  logic                          sign_in,
  output logic                          sin_req_out,
  output logic [$clog2(NUM_ANGLES)-1:0] angle_idx_out,
  output logic [SIN_WIDTH-1:0]          sin_theta_out,
  output logic                          sign_bit_out,
  output logic                          tx_enable_out,
  output logic                          period_start_out,
  output logic                          listen_out,
  output logic                          overrun_out,
  output logic                          busy_out
);

  // state    | meaning
  // S_IDLE   | parked, waiting for enable_in
  // S_FETCH  | sin_req high, waiting for LUT strobe
  // S_SETTLE | sin/sign held, waiting SETTLE_CYCLES before burst
  // S_BURST  | tx_enable high for BURST_DURATION cycles
  // S_LISTEN | receive window until the period boundary

  localparam int unsigned AW = $clog2(NUM_ANGLES);
  localparam logic [AW-1:0] ANGLE_LAST  = AW'(NUM_ANGLES - 1);
  localparam logic [31:0]   PERIOD_LAST = 32'(PERIOD_DURATION - 1);
  localparam logic [31:0]   SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   BURST_LOAD  = 32'(BURST_DURATION - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_BURST,
    S_LISTEN
  } state_e;

  state_e               state_q;
  logic [AW-1:0]        angle_q, angle_d;
  logic                 dir_up_q, dir_up_d;
  logic [31:0]          period_cnt_q, period_cnt_d;
  logic [31:0]          timer_q;
  logic [SIN_WIDTH-1:0] sin_q;
  logic                 sign_q;
  logic                 sin_req_q;
  logic                 tx_q;
  logic                 ps_q;
  logic                 listen_q;
  logic                 overrun_q;
  logic                 busy_q;
  logic                 late_entry;

  always_comb begin
    angle_d  = angle_q;
    dir_up_d = dir_up_q;
    if (!hold_in) begin
      if (dir_up_q) begin
        if (angle_q == ANGLE_LAST) begin
          dir_up_d = 1'b0;
          angle_d  = angle_q - AW'(1);
        end else begin
          angle_d  = angle_q + AW'(1);
        end
      end else begin
        if (angle_q == '0) begin
          dir_up_d = 1'b1;
          angle_d  = angle_q + AW'(1);
        end else begin
          angle_d  = angle_q - AW'(1);
        end
      end
    end
  end

  assign period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 32'd1;
  // Count seen in the first LISTEN cycle already at/after the boundary means the period ran long.
  assign late_entry = ({1'b0, period_cnt_q} + 33'd1) >= {1'b0, PERIOD_LAST};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      angle_q      <= '0;
      dir_up_q     <= 1'b1;
      period_cnt_q <= '0;
      timer_q      <= '0;
      sin_q        <= '0;
      sign_q       <= 1'b0;
      sin_req_q    <= 1'b0;
      tx_q         <= 1'b0;
      ps_q         <= 1'b0;
      listen_q     <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ps_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_in) begin
            state_q      <= S_FETCH;
            period_cnt_q <= '0;
            ps_q         <= 1'b1;
            sin_req_q    <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_FETCH: begin
          period_cnt_q <= period_cnt_d;
          if (sin_valid_in) begin
            sin_q     <= sin_in;
            sign_q    <= sign_in;
            sin_req_q <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              state_q <= S_BURST;
              timer_q <= BURST_LOAD;
              tx_q    <= 1'b1;
            end else begin
              state_q <= S_SETTLE;
              timer_q <= SETTLE_LOAD;
            end
          end
        end
        S_SETTLE: begin
          period_cnt_q <= period_cnt_d;
          if (timer_q == '0) begin
            state_q <= S_BURST;
            timer_q <= BURST_LOAD;
            tx_q    <= 1'b1;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_BURST: begin
          period_cnt_q <= period_cnt_d;
          if (timer_q == '0) begin
            state_q  <= S_LISTEN;
            tx_q     <= 1'b0;
            listen_q <= 1'b1;
            if (late_entry) overrun_q <= 1'b1;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_LISTEN: begin
          if (period_cnt_q >= PERIOD_LAST) begin
            listen_q     <= 1'b0;
            period_cnt_q <= '0;
            if (enable_in) begin
              state_q   <= S_FETCH;
              angle_q   <= angle_d;
              dir_up_q  <= dir_up_d;
              ps_q      <= 1'b1;
              sin_req_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            period_cnt_q <= period_cnt_d;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          sin_req_q <= 1'b0;
          tx_q      <= 1'b0;
          listen_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sin_req_out      = sin_req_q;
  assign angle_idx_out    = angle_q;
  assign sin_theta_out    = sin_q;
  assign sign_bit_out     = sign_q;
  assign tx_enable_out    = tx_q;
  assign period_start_out = ps_q;
  assign listen_out       = listen_q;
  assign overrun_out      = overrun_q;
  assign busy_out         = busy_q;

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Scoreboard bench for beam_sweep_scheduler: expected per-period timing/angle records are queued by
// the stimulus and compared by a monitor when each period's listen window closes.
`timescale 1ns/1ps
module tb_beam_sweep_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        enable_in = 1'b0;
  logic        hold_in = 1'b0;
  logic        sin_valid_in = 1'b0;
  logic [16:0] sin_in = '0;
  logic        sign_in = 1'b0;
  logic        sin_req_out;
  logic [1:0]  angle_idx_out;
  logic [16:0] sin_theta_out;
  logic        sign_bit_out;
  logic        tx_enable_out;
  logic        period_start_out;
  logic        listen_out;
  logic        overrun_out;
  logic        busy_out;

  beam_sweep_scheduler #(
    .PERIOD_DURATION(64),
    .BURST_DURATION (8),
    .SETTLE_CYCLES  (4),
    .NUM_ANGLES     (4),
    .SIN_WIDTH      (17)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .hold_in         (hold_in),
    .sin_valid_in    (sin_valid_in),
    .sin_in          (sin_in),
    .sign_in         (sign_in),
    .sin_req_out     (sin_req_out),
    .angle_idx_out   (angle_idx_out),
    .sin_theta_out   (sin_theta_out),
    .sign_bit_out    (sign_bit_out),
    .tx_enable_out   (tx_enable_out),
    .period_start_out(period_start_out),
    .listen_out      (listen_out),
    .overrun_out     (overrun_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int angle;
    int gap;
    int tx_off;
    int tx_len;
    int li_off;
    int li_len;
    int ovr;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_start_cyc = 0;
  int          n_starts = 0;
  int          lut_delay = 1;
  logic [16:0] sin_tab [4] = '{17'd6393, 17'd19024, 17'd31164, 17'd42261};
  logic        sign_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int angle, input int gap, input bit late);
    exp_t e;
    e.angle = angle;
    e.gap   = gap;
    if (late) begin
      e.tx_off = 75; e.tx_len = 8; e.li_off = 83; e.li_len = 1;
    end else begin
      e.tx_off = 6;  e.tx_len = 8; e.li_off = 14; e.li_len = 50;
    end
    e.ovr = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_ovr(input int angle, input int gap, input bit late);
    push(angle, gap, late);
    exp_q[exp_q.size()-1].ovr = 1;
  endtask

  task automatic wait_starts(input int n, input string tag);
    int t = 0;
    while (n_starts < n && t < 5000) begin
      @(posedge clk_in);
      t++;
    end
    chk(tag, n_starts, n);
  endtask

  // LUT model: answers after lut_delay cycles of sin_req; injects junk strobes during bursts
  int req_age = 0;
  initial begin : lut
    forever begin
      @(posedge clk_in);
      #1;
      if (sin_req_out) req_age++;
      else req_age = 0;
      if (sin_req_out && req_age == lut_delay + 1) begin
        sin_valid_in = 1'b1;
        sin_in       = sin_tab[angle_idx_out];
        sign_in      = sign_tab[angle_idx_out];
      end else if (tx_enable_out) begin
        sin_valid_in = 1'b1;
        sin_in       = 17'h1ABCD;
        sign_in      = ~sign_tab[angle_idx_out];
      end else begin
        sin_valid_in = 1'b0;
      end
    end
  end

  int          cur_start, tx_off, tx_len, li_off, li_len, st_gap, st_angle;
  logic [16:0] tx_sin, li_sin;
  logic        tx_sign, li_sign, li_ovr;
  bit          in_per = 0;

  task automatic finish_period();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_period: angle %0d with no expectation queued", st_angle);
      return;
    end
    e = exp_q.pop_front();
    chk("angle", st_angle, e.angle);
    chk("start_gap", st_gap, e.gap);
    chk("tx_offset", tx_off, e.tx_off);
    chk("tx_len", tx_len, e.tx_len);
    chk("listen_offset", li_off, e.li_off);
    chk("listen_len", li_len, e.li_len);
    chk("overrun", li_ovr, e.ovr);
    chk("sin_at_burst", tx_sin, sin_tab[e.angle]);
    chk("sign_at_burst", tx_sign, sign_tab[e.angle]);
    chk("sin_at_listen_end", li_sin, sin_tab[e.angle]);
    chk("sign_at_listen_end", li_sign, sign_tab[e.angle]);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        in_per = 0;
      end else begin
        if (in_per && li_len > 0 && !listen_out) begin
          finish_period();
          in_per = 0;
        end
        if (period_start_out) begin
          n_starts++;
          in_per = 1;
          st_gap = cyc - last_start_cyc;
          last_start_cyc = cyc;
          cur_start = cyc;
          st_angle = int'(angle_idx_out);
          tx_len = 0; li_len = 0; tx_off = -1; li_off = -1;
        end
        if (in_per) begin
          if (tx_enable_out) begin
            if (tx_len == 0) begin
              tx_off  = cyc - cur_start;
              tx_sin  = sin_theta_out;
              tx_sign = sign_bit_out;
            end
            tx_len++;
          end
          if (listen_out) begin
            if (li_len == 0) li_off = cyc - cur_start;
            li_len++;
            li_sin  = sin_theta_out;
            li_sign = sign_bit_out;
            li_ovr  = overrun_out;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int  t;
    bit  saw;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_sin_req", sin_req_out, 0);
    chk("rst_tx", tx_enable_out, 0);
    chk("rst_listen", listen_out, 0);
    chk("rst_overrun", overrun_out, 0);
    chk("rst_angle", angle_idx_out, 0);
    chk("rst_sin", sin_theta_out, 0);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("idle_busy", busy_out, 0);
    chk("idle_sin_req", sin_req_out, 0);

    // free run: ping-pong 0,1,2,3,2,1,0,1
    enable_in = 1'b1;
    last_start_cyc = cyc;
    push(0, 1, 0);  push(1, 64, 0); push(2, 64, 0); push(3, 64, 0);
    push(2, 64, 0); push(1, 64, 0); push(0, 64, 0); push(1, 64, 0);
    wait_starts(8, "wait_start8");

    // hold during period 8 repeats angle 1, then 2,3
    repeat (20) @(posedge clk_in);
    #1 hold_in = 1'b1;
    push(1, 64, 0); push(2, 64, 0); push(3, 64, 0);
    wait_starts(9, "wait_start9");
    repeat (20) @(posedge clk_in);
    #1 hold_in = 1'b0;

    // slow LUT on period 12 forces an overrun
    wait_starts(11, "wait_start11");
    repeat (10) @(posedge clk_in);
    #1 lut_delay = 70;
    push_ovr(2, 64, 1);
    wait_starts(12, "wait_start12");
    repeat (80) @(posedge clk_in);
    #1 lut_delay = 1;
    push_ovr(1, 84, 0);
    wait_starts(13, "wait_start13");
    push_ovr(0, 64, 0);

    // drop enable mid-burst of period 14
    wait_starts(14, "wait_start14");
    repeat (8) @(posedge clk_in);
    #1 enable_in = 1'b0;
    t = 0;
    while (busy_out && t < 200) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    chk("idle_offset", cyc - last_start_cyc, 64);
    chk("idle_busy2", busy_out, 0);
    chk("idle_listen", listen_out, 0);
    chk("idle_tx", tx_enable_out, 0);
    chk("idle_angle_kept", angle_idx_out, 0);
    chk("idle_overrun_sticky", overrun_out, 1);
    saw = 0;
    repeat (20) begin
      @(posedge clk_in);
      #1;
      if (sin_req_out || busy_out) saw = 1;
    end
    chk("idle_quiet", saw, 0);
    chk("idle_no_start", n_starts, 14);

    // re-enable, then reset in the middle of the burst
    @(posedge clk_in);
    #1 enable_in = 1'b1;
    last_start_cyc = cyc;
    wait_starts(15, "wait_start15");
    chk("resume_angle", angle_idx_out, 0);
    repeat (8) @(posedge clk_in);
    chk("pre_reset_tx", tx_enable_out, 1);
    #3 rst_in = 1'b0;
    #1;
    chk("async_tx", tx_enable_out, 0);
    chk("async_busy", busy_out, 0);
    chk("async_sin_req", sin_req_out, 0);
    chk("async_listen", listen_out, 0);
    chk("async_overrun", overrun_out, 0);
    chk("async_sin", sin_theta_out, 0);
    push(0, 1, 0); push(1, 64, 0); push(2, 64, 0);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    last_start_cyc = cyc;

    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk_in);
      t++;
    end
    chk("queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
